// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter and sequencer that shares one single-port scratch
// memory between two requesters (A and B).
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   a_valid/a_write/a_addr/a_wdata   requester A command (held until a_ready)
//   a_ready                     A command accepted this cycle (combinational)
//   a_rvalid/a_rdata            A read response pulse / last read data
//   b_*                         same set for requester B
//   mem_read/mem_write          memory strobes (never both high)
//   mem_addr/mem_wdata          memory address / write data (held outside ISSUE)
//   mem_rdata                   memory read data, valid the cycle after mem_read
//   busy                        FSM is not in IDLE
//
// Command flow: IDLE (grant) -> ISSUE (strobe) -> IDLE for writes, or
// ISSUE -> WAIT -> CAPTURE -> IDLE for reads.
module mem_arbiter #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   input  logic                  a_write,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_wdata,
   output logic                  a_ready,
   output logic                  a_rvalid,
   output logic [DATA_WIDTH-1:0] a_rdata,
   input  logic                  b_valid,
   input  logic                  b_write,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   output logic                  b_ready,
   output logic                  b_rvalid,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

   state_e                state_q;
   logic                  prio_q;       // 0 = A wins a contested grant, 1 = B
   logic                  owner_q;      // 0 = A, 1 = B
   logic                  cmd_write_q;
   logic [ADDR_WIDTH-1:0] cmd_addr_q;
   logic [DATA_WIDTH-1:0] cmd_wdata_q;
   logic                  mem_read_q;
   logic                  mem_write_q;
   logic                  busy_q;
   logic                  a_rvalid_q;
   logic                  b_rvalid_q;
   logic [DATA_WIDTH-1:0] a_rdata_q;
   logic [DATA_WIDTH-1:0] b_rdata_q;

   logic                  grant_a;
   logic                  grant_b;
   logic                  sel_write;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;

   // Winner selection: a lone requester always wins; contention goes to prio_q.
   always_comb begin
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      if (state_q == StIdle) begin
         grant_a = a_valid & (~b_valid | ~prio_q);
         grant_b = b_valid & (~a_valid |  prio_q);
      end
      sel_write = grant_b ? b_write : a_write;
      sel_addr  = grant_b ? b_addr  : a_addr;
      sel_wdata = grant_b ? b_wdata : a_wdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         prio_q      <= 1'b0;
         owner_q     <= 1'b0;
         cmd_write_q <= 1'b0;
         cmd_addr_q  <= '0;
         cmd_wdata_q <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         busy_q      <= 1'b0;
         a_rvalid_q  <= 1'b0;
         b_rvalid_q  <= 1'b0;
         a_rdata_q   <= '0;
         b_rdata_q   <= '0;
      end else begin
         // Strobes and response pulses last a single cycle.
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         a_rvalid_q  <= 1'b0;
         b_rvalid_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (grant_a || grant_b) begin
                  owner_q     <= grant_b;
                  prio_q      <= ~grant_b;
                  cmd_write_q <= sel_write;
                  cmd_addr_q  <= sel_addr;
                  cmd_wdata_q <= sel_wdata;
                  // Strobes are registered here so they appear during ISSUE.
                  mem_write_q <= sel_write;
                  mem_read_q  <= ~sel_write;
                  busy_q      <= 1'b1;
                  state_q     <= StIssue;
               end
            end
            StIssue: begin
               busy_q  <= ~cmd_write_q;
               state_q <= cmd_write_q ? StIdle : StWait;
            end
            StWait: begin
               state_q <= StCapture;
            end
            StCapture: begin
               if (owner_q) begin
                  b_rdata_q  <= mem_rdata;
                  b_rvalid_q <= 1'b1;
               end else begin
                  a_rdata_q  <= mem_rdata;
                  a_rvalid_q <= 1'b1;
               end
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign a_ready   = grant_a;
   assign b_ready   = grant_b;
   assign a_rvalid  = a_rvalid_q;
   assign b_rvalid  = b_rvalid_q;
   assign a_rdata   = a_rdata_q;
   assign b_rdata   = b_rdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   // The command register only changes on a grant, so it holds outside ISSUE.
   assign mem_addr  = cmd_addr_q;
   assign mem_wdata = cmd_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous scratch-memory model.
module tb_mem_arbiter;

   logic       clk;
   logic       rst_n;
   logic       a_valid, a_write, a_ready, a_rvalid;
   logic [4:0] a_addr;
   logic [7:0] a_wdata, a_rdata;
   logic       b_valid, b_write, b_ready, b_rvalid;
   logic [4:0] b_addr;
   logic [7:0] b_wdata, b_rdata;
   logic       mem_read, mem_write, busy;
   logic [4:0] mem_addr;
   logic [7:0] mem_wdata, mem_rdata;

   logic [7:0] mem_model [32];

   int checks = 0;
   int passes = 0;

   mem_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a_valid   (a_valid),
      .a_write   (a_write),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_ready   (a_ready),
      .a_rvalid  (a_rvalid),
      .a_rdata   (a_rdata),
      .b_valid   (b_valid),
      .b_write   (b_write),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_ready   (b_ready),
      .b_rvalid  (b_rvalid),
      .b_rdata   (b_rdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scratch memory: preloaded with 0x40+addr while reset is held.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) mem_model[i] <= 8'h40 + 8'(i);
         mem_rdata <= 8'h00;
      end else begin
         if (mem_write) mem_model[mem_addr] <= mem_wdata;
         if (mem_read)  mem_rdata <= mem_model[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      a_valid = 0; a_write = 0; a_addr = '0; a_wdata = '0;
      b_valid = 0; b_write = 0; b_addr = '0; b_wdata = '0;
   endtask

   task automatic do_reset();
      rst_n = 0;
      idle_inputs();
      tick();
      tick();
      rst_n = 1;
      tick();
   endtask

   initial begin
      int own;
      int prev_own;
      logic [4:0] prev_addr;
      logic [4:0] b_seq [3];

      rst_n = 0;
      idle_inputs();
      tick();
      // Reset state
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_strobes", {mem_read, mem_write}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
      chk("rst_rdata", {a_rdata, b_rdata}, 0);
      tick();
      rst_n = 1;
      tick();

      // A writes 0x5A to addr 3
      a_valid = 1; a_write = 1; a_addr = 5'd3; a_wdata = 8'h5A;
      #1;
      chk("w_a_ready", a_ready, 1);
      chk("w_b_ready", b_ready, 0);
      tick();
      a_valid = 0;
      chk("w_mem_write", mem_write, 1);
      chk("w_mem_read", mem_read, 0);
      chk("w_mem_addr", mem_addr, 3);
      chk("w_mem_wdata", mem_wdata, 8'h5A);
      chk("w_busy_t1", busy, 1);
      chk("w_ready_t1", a_ready, 0);
      tick();
      chk("w_busy_t2", busy, 0);
      chk("w_strobe_t2", mem_write, 0);
      chk("w_addr_hold", mem_addr, 3);

      // A reads addr 3 back
      a_valid = 1; a_write = 0; a_addr = 5'd3;
      #1;
      chk("r_a_ready", a_ready, 1);
      tick();
      a_valid = 0;
      chk("r_mem_read", mem_read, 1);
      chk("r_mem_write", mem_write, 0);
      tick();
      chk("r_wait_strobe", mem_read, 0);
      chk("r_wait_busy", busy, 1);
      tick();
      chk("r_cap_rvalid", a_rvalid, 0);
      tick();
      chk("r_a_rvalid", a_rvalid, 1);
      chk("r_a_rdata", a_rdata, 8'h5A);
      chk("r_b_rvalid", b_rvalid, 0);
      chk("r_b_rdata", b_rdata, 0);
      chk("r_busy_t4", busy, 0);
      tick();
      chk("r_pulse_end", a_rvalid, 0);

      // Both valid out of reset: A then B
      do_reset();
      a_valid = 1; a_write = 1; a_addr = 5'd1; a_wdata = 8'h11;
      b_valid = 1; b_write = 1; b_addr = 5'd2; b_wdata = 8'h22;
      #1;
      chk("c_a_first", a_ready, 1);
      chk("c_b_wait", b_ready, 0);
      tick();
      a_valid = 0;
      chk("c_b_not_in_issue", b_ready, 0);
      chk("c_a_addr", mem_addr, 1);
      tick();
      chk("c_b_second", b_ready, 1);
      tick();
      b_valid = 0;
      chk("c_b_write", mem_write, 1);
      chk("c_b_addr", mem_addr, 2);
      chk("c_b_wdata", mem_wdata, 8'h22);
      tick();
      chk("c_mem1", mem_model[1], 8'h11);
      chk("c_mem2", mem_model[2], 8'h22);

      // Both hold 4 reads each: A at 4..7, B at 8..11 (preloaded 0x40+addr)
      a_valid = 1; a_write = 0; a_addr = 5'd4;
      b_valid = 1; b_write = 0; b_addr = 5'd8;
      prev_own = 0;
      prev_addr = '0;
      for (int g = 0; g < 8; g++) begin
         own = g % 2;
         #1;
         chk($sformatf("rr_a_ready_%0d", g), a_ready, (own == 0) ? 1 : 0);
         chk($sformatf("rr_b_ready_%0d", g), b_ready, (own == 1) ? 1 : 0);
         if (g > 0) begin
            chk($sformatf("rr_a_rvalid_%0d", g), a_rvalid, (prev_own == 0) ? 1 : 0);
            chk($sformatf("rr_b_rvalid_%0d", g), b_rvalid, (prev_own == 1) ? 1 : 0);
            chk($sformatf("rr_rdata_%0d", g), (prev_own == 0) ? a_rdata : b_rdata,
                8'h40 + 8'(prev_addr));
         end
         prev_own  = own;
         prev_addr = (own == 0) ? a_addr : b_addr;
         tick();
         chk($sformatf("rr_issue_addr_%0d", g), mem_addr, prev_addr);
         chk($sformatf("rr_issue_read_%0d", g), mem_read, 1);
         if (own == 0) begin
            a_addr = a_addr + 1;
            if (g / 2 == 3) a_valid = 0;
         end else begin
            b_addr = b_addr + 1;
            if (g / 2 == 3) b_valid = 0;
         end
         for (int c = 0; c < 3; c++) begin
            chk($sformatf("rr_strobe_excl_%0d_%0d", g, c), mem_read & mem_write, 0);
            tick();
         end
      end
      chk("rr_last_b_rvalid", b_rvalid, 1);
      chk("rr_last_a_rvalid", a_rvalid, 0);
      chk("rr_last_b_rdata", b_rdata, 8'h4B);
      chk("rr_last_a_rdata", a_rdata, 8'h47);

      // Reset while a B read sits in WAIT
      b_valid = 1; b_write = 0; b_addr = 5'd2;
      #1;
      chk("rw_b_ready", b_ready, 1);
      tick();
      b_valid = 0;
      tick();
      chk("rw_in_wait", busy, 1);
      rst_n = 0;
      #1;
      chk("rw_busy", busy, 0);
      chk("rw_strobes", {mem_read, mem_write}, 0);
      chk("rw_b_rdata", b_rdata, 0);
      chk("rw_mem_addr", mem_addr, 0);
      tick();
      rst_n = 1;
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("rw_no_rvalid_%0d", c), {a_rvalid, b_rvalid}, 0);
      end
      a_valid = 1; a_write = 1; a_addr = 5'd5; a_wdata = 8'h01;
      b_valid = 1; b_write = 1; b_addr = 5'd6; b_wdata = 8'h02;
      #1;
      chk("rw_a_first", a_ready, 1);
      chk("rw_b_second", b_ready, 0);
      tick();
      a_valid = 0;
      tick();
      chk("rw_b_grant", b_ready, 1);
      tick();
      b_valid = 0;
      tick();

      // Only B: writes to 0, 31, 0
      b_seq[0] = 5'd0; b_seq[1] = 5'd31; b_seq[2] = 5'd0;
      b_valid = 1; b_write = 1;
      for (int k = 0; k < 3; k++) begin
         b_addr  = b_seq[k];
         b_wdata = 8'(k + 1);
         #1;
         chk($sformatf("bo_b_ready_%0d", k), b_ready, 1);
         chk($sformatf("bo_a_ready_%0d", k), a_ready, 0);
         tick();
         chk($sformatf("bo_mem_addr_%0d", k), mem_addr, b_seq[k]);
         chk($sformatf("bo_mem_write_%0d", k), mem_write, 1);
         tick();
      end
      b_valid = 0;
      chk("bo_mem31", mem_model[31], 8'h02);
      chk("bo_mem0", mem_model[0], 8'h03);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port round-robin arbiter and sequencer for the single-port scratch memory (5-bit address, 8-bit data, `read`/`write` strobes, synchronous registered `data_out`). It accepts read and write commands from two requesters (A and B), serialises them onto the memory strobes one at a time, and returns read data to the requester that issued the read. It sits between the requester logic and the memory-side signals that the tester modport of the memory interface otherwise drives.

## Interface
- `ADDR_WIDTH`, 5, memory address width
- `DATA_WIDTH`, 8, memory data width
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `a_valid`  in  1  requester A command valid; held until `a_ready`
- `a_write`  in  1  A command type: 1 = write, 0 = read
- `a_addr`  in  ADDR_WIDTH  A address
- `a_wdata`  in  DATA_WIDTH  A write data
- `a_ready`  out  1  A command accepted this cycle (combinational)
- `a_rvalid`  out  1  one-cycle pulse, A read data valid
- `a_rdata`  out  DATA_WIDTH  A read data, holds last value
- `b_valid`, `b_write`, `b_addr`, `b_wdata`, `b_ready`, `b_rvalid`, `b_rdata`: same as A, for requester B
- `mem_read`  out  1  memory read strobe
- `mem_write`  out  1  memory write strobe
- `mem_addr`  out  ADDR_WIDTH  memory address
- `mem_wdata`  out  DATA_WIDTH  memory write data
- `mem_rdata`  in  DATA_WIDTH  memory read data, valid the cycle after `mem_read`
- `busy`  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE
  - If neither valid is high, stay in IDLE.
  - If exactly one valid is high, that requester wins.
  - If both are high, the winner is the requester named by the round-robin pointer `prio` (0 = A, 1 = B).
  - The winner's `*_ready` goes high combinationally for that cycle only.
  - Its `write`, `addr` and `wdata` are registered into the command register together with the owner ID.
  - After a grant, `prio` is set to the non-winner. It updates on every grant, including uncontested ones.
  - Next state: ISSUE.
- ISSUE (1 cycle)
  - Drives `mem_addr`/`mem_wdata` from the command register.
  - Asserts exactly one strobe: `mem_write` for a write, `mem_read` for a read.
  - Next state: IDLE for a write, WAIT for a read.
- WAIT (1 cycle): strobes low; the memory presents `mem_rdata`. Next state: CAPTURE.
- CAPTURE (1 cycle)
  - `mem_rdata` is registered into the owner's `*_rdata`, and the owner's `*_rvalid` pulses in the following cycle (registered).
  - Next state: IDLE.
- Every `*_ready` is low outside IDLE; at most one `*_ready` is high per cycle.
- `mem_read` and `mem_write` are never high together.
- `mem_addr`/`mem_wdata` hold their last values outside ISSUE.
- Responses have no backpressure; the requester must accept an `*_rvalid` pulse.
- `a_rvalid` and `b_rvalid` are never high together.
- The non-owner's `*_rdata` is never modified.

## Timing
- Reset values: state = IDLE, `prio` = 0 (A), all strobes/ready/rvalid/busy = 0, `mem_addr`/`mem_wdata`/`*_rdata` = 0.
- Accept at cycle T (ready high):
  - Write: `mem_write` at T+1, next accept possible at T+2.
  - Read: `mem_read` at T+1, memory data at T+2, captured at T+3, `*_rvalid` high at T+4. Next accept possible at T+4, so an `rvalid` pulse can coincide with the next grant.
- Throughput: one write per 2 cycles, one read per 4 cycles.
- `busy` is high from T+1 until the FSM returns to IDLE.
- A valid that is held while the other requester is served is granted at the next IDLE cycle.
- Contested arbitration strictly alternates: with both valids held, grants go A, B, A, B…
- Reset mid-operation (any state): FSM returns to IDLE immediately.
  - Any pending strobe, `rvalid` or in-flight read response is dropped.
  - `prio` returns to A.
- A `*_valid` deasserted before ready is a protocol violation; it is not required to be handled.

## Test plan
- Reset, then A writes 0x5A to addr 3 → `a_ready` at T, `mem_write`=1 with `mem_addr`=3 and `mem_wdata`=0x5A at T+1, `busy` low at T+2.
- A reads addr 3 after that write (memory model returns 0x5A) → `mem_read` at T+1, `a_rvalid`=1 with `a_rdata`=0x5A at T+4, `b_rvalid` stays 0 and `b_rdata` unchanged.
- Both valid out of reset; A writes 0x11 to addr 1, B writes 0x22 to addr 2 → A granted first, B granted 2 cycles later, memory holds 0x11 at 1 and 0x22 at 2.
- Both hold 4 back-to-back reads each → grants alternate A, B, A, B…, 8 `rvalid` pulses on alternating owners with correct data, no cycle with both strobes high.
- Assert `rst_n`=0 in WAIT of a B read → no `b_rvalid` pulse, outputs at reset values. After release, simultaneous requests grant A first.
- Only B active, issuing 3 consecutive writes to addrs 0, 31, 0 (wrap-end address) → each granted at every IDLE cycle (`prio` toggles without blocking), `mem_addr` sequence 0, 31, 0.
